// File: rtl/lt100_bus_arbiter_pkg.sv
// Shared types and constants for the two-master lt100 bus arbiter.
package lt100_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic GNT_M0 = 1'b0;
    localparam logic GNT_M1 = 1'b1;

    localparam int CNT_WIDTH = 16;

    function automatic logic [1:0] grant_onehot(input logic idx);
        return (idx == GNT_M1) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/lt100_bus_arbiter_if.sv
// One lt100 request/response channel; master drives the request, slave answers.
interface lt100_bus_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                    enable;
    logic                    wr_en;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [DATA_WIDTH-1:0]   i_data;
    logic [DATA_WIDTH/8-1:0] be;
    logic                    ready;
    logic [DATA_WIDTH-1:0]   o_data;
    logic                    bus_err;

    modport master (
        output enable, wr_en, addr, i_data, be,
        input  ready, o_data, bus_err
    );

    modport slave (
        input  enable, wr_en, addr, i_data, be,
        output ready, o_data, bus_err
    );
endinterface

// File: rtl/lt100_bus_arbiter.sv
// Round-robin arbiter sharing one lt100 bus between masters m0 and m1.
//   state   | meaning
//   IDLE    | no owner; waits for a request while the bus is quiet
//   BUSY    | request issued on s, waiting for s.ready / timeout / abort
//   DONE    | completion held until the owner drops enable and s.ready is low
module lt100_bus_arbiter
    import lt100_pkg::*;
#(
    parameter int          ADDR_WIDTH = 32,
    parameter int          DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                clk,
    input  logic                rst,
    lt100_bus_arbiter_if.slave  m0,
    lt100_bus_arbiter_if.slave  m1,
    lt100_bus_arbiter_if.master s,
    output logic [1:0]          grant
);

    localparam int BE_WIDTH = DATA_WIDTH / 8;
    localparam bit TO_EN = (TIMEOUT != 0);
    localparam logic [CNT_WIDTH-1:0] TO_LAST =
        (TIMEOUT == 0) ? '0 : CNT_WIDTH'(TIMEOUT - 1);

    state_t                          state_q, state_d;
    logic                            idx_q, idx_d;
    logic                            last_q, last_d;
    logic [1:0]                      grant_q, grant_d;
    logic [CNT_WIDTH-1:0]            cnt_q, cnt_d;

    logic                            s_en_q, s_en_d;
    logic                            s_wr_q, s_wr_d;
    logic [ADDR_WIDTH-1:0]           s_addr_q, s_addr_d;
    logic [DATA_WIDTH-1:0]           s_data_q, s_data_d;
    logic [BE_WIDTH-1:0]             s_be_q, s_be_d;

    logic [1:0]                      rdy_q, rdy_d;
    logic [1:0]                      err_q, err_d;
    logic [1:0][DATA_WIDTH-1:0]      rdata_q, rdata_d;

    logic [1:0]                      m_en;
    logic [1:0]                      m_wr;
    logic [1:0][ADDR_WIDTH-1:0]      m_addr;
    logic [1:0][DATA_WIDTH-1:0]      m_data;
    logic [1:0][BE_WIDTH-1:0]        m_be;
    logic                            win;

    assign m_en   = {m1.enable, m0.enable};
    assign m_wr   = {m1.wr_en,  m0.wr_en};
    assign m_addr = {m1.addr,   m0.addr};
    assign m_data = {m1.i_data, m0.i_data};
    assign m_be   = {m1.be,     m0.be};

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        last_d   = last_q;
        grant_d  = grant_q;
        cnt_d    = cnt_q;
        s_en_d   = s_en_q;
        s_wr_d   = s_wr_q;
        s_addr_d = s_addr_q;
        s_data_d = s_data_q;
        s_be_d   = s_be_q;
        rdy_d    = rdy_q;
        err_d    = err_q;
        rdata_d  = rdata_q;
        win      = GNT_M0;

        case (state_q)
            ST_IDLE: begin
                if ((m_en != 2'b00) && !s.ready) begin
                    // Contention goes to whichever master was not served last.
                    win      = (m_en == 2'b11) ? ~last_q : m_en[GNT_M1];
                    idx_d    = win;
                    grant_d  = grant_onehot(win);
                    s_en_d   = 1'b1;
                    s_wr_d   = m_wr[win];
                    s_addr_d = m_addr[win];
                    s_data_d = m_data[win];
                    s_be_d   = m_be[win];
                    cnt_d    = '0;
                    state_d  = ST_BUSY;
                end
            end
            ST_BUSY: begin
                cnt_d = cnt_q + 1'b1;
                // An abandoned request never produces a ready, even if the slave answers now.
                if (!m_en[idx_q]) begin
                    s_en_d  = 1'b0;
                    state_d = ST_DONE;
                end else if (s.ready) begin
                    rdata_d[idx_q] = s.o_data;
                    err_d[idx_q]   = s.bus_err;
                    rdy_d[idx_q]   = 1'b1;
                    s_en_d         = 1'b0;
                    state_d        = ST_DONE;
                end else if (TO_EN && (cnt_q == TO_LAST)) begin
                    rdata_d[idx_q] = '0;
                    err_d[idx_q]   = 1'b1;
                    rdy_d[idx_q]   = 1'b1;
                    s_en_d         = 1'b0;
                    state_d        = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!m_en[idx_q] && !s.ready) begin
                    rdy_d[idx_q] = 1'b0;
                    err_d[idx_q] = 1'b0;
                    last_d       = idx_q;
                    grant_d      = 2'b00;
                    state_d      = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            idx_q    <= GNT_M0;
            last_q   <= GNT_M1;
            grant_q  <= 2'b00;
            cnt_q    <= '0;
            s_en_q   <= 1'b0;
            s_wr_q   <= 1'b0;
            s_addr_q <= '0;
            s_data_q <= '0;
            s_be_q   <= '0;
            rdy_q    <= 2'b00;
            err_q    <= 2'b00;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            last_q   <= last_d;
            grant_q  <= grant_d;
            cnt_q    <= cnt_d;
            s_en_q   <= s_en_d;
            s_wr_q   <= s_wr_d;
            s_addr_q <= s_addr_d;
            s_data_q <= s_data_d;
            s_be_q   <= s_be_d;
            rdy_q    <= rdy_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
        end
    end

    assign s.enable   = s_en_q;
    assign s.wr_en    = s_wr_q;
    assign s.addr     = s_addr_q;
    assign s.i_data   = s_data_q;
    assign s.be       = s_be_q;

    assign m0.ready   = rdy_q[GNT_M0];
    assign m0.bus_err = err_q[GNT_M0];
    assign m0.o_data  = rdata_q[GNT_M0];
    assign m1.ready   = rdy_q[GNT_M1];
    assign m1.bus_err = err_q[GNT_M1];
    assign m1.o_data  = rdata_q[GNT_M1];

    assign grant      = grant_q;

endmodule

// File: tb/tb_lt100_bus_arbiter.sv
// Directed bench for lt100_bus_arbiter with TIMEOUT=8.
module tb_lt100_bus_arbiter;

    localparam logic [31:0] A0 = 32'h0000_0010;
    localparam logic [31:0] A1 = 32'h0000_0200;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] grant;
    int         n_vec = 0;
    int         n_err = 0;

    lt100_bus_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) m0_bus ();
    lt100_bus_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) m1_bus ();
    lt100_bus_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) s_bus ();

    lt100_bus_arbiter #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .TIMEOUT   (8)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .m0   (m0_bus),
        .m1   (m1_bus),
        .s    (s_bus),
        .grant(grant)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Waits for the grant, answers after lat cycles, then the owner drops enable.
    task automatic serve(input int who, input logic [31:0] rdata, input int lat);
        int waited = 0;
        while (!s_bus.enable && waited < 20) begin
            step();
            waited++;
        end
        chk("s_enable_rise", s_bus.enable, 1);
        chk("grant", grant, (who != 0) ? 2'b10 : 2'b01);
        chk("s_addr", s_bus.addr, (who != 0) ? A1 : A0);
        repeat (lat - 1) step();
        chk("ready_early", (who != 0) ? m1_bus.ready : m0_bus.ready, 0);
        s_bus.ready  = 1'b1;
        s_bus.o_data = rdata;
        step();
        s_bus.ready  = 1'b0;
        chk("ready", (who != 0) ? m1_bus.ready : m0_bus.ready, 1);
        chk("o_data", (who != 0) ? m1_bus.o_data : m0_bus.o_data, rdata);
        chk("bus_err", (who != 0) ? m1_bus.bus_err : m0_bus.bus_err, 0);
        chk("other_ready", (who != 0) ? m0_bus.ready : m1_bus.ready, 0);
        chk("s_enable_fall", s_bus.enable, 0);
        if (who != 0) m1_bus.enable = 1'b0;
        else          m0_bus.enable = 1'b0;
        step();
        chk("grant_idle", grant, 2'b00);
        chk("ready_clear", (who != 0) ? m1_bus.ready : m0_bus.ready, 0);
    endtask

    initial begin
        rst = 1'b1;
        m0_bus.enable = 1'b0; m0_bus.wr_en = 1'b0; m0_bus.addr = A0;
        m0_bus.i_data = '0;   m0_bus.be = 4'hF;
        m1_bus.enable = 1'b0; m1_bus.wr_en = 1'b0; m1_bus.addr = A1;
        m1_bus.i_data = '0;   m1_bus.be = 4'hF;
        s_bus.ready = 1'b0;   s_bus.o_data = '0;   s_bus.bus_err = 1'b0;
        step();
        step();
        rst = 1'b0;
        chk("rst_grant", grant, 2'b00);
        chk("rst_s_enable", s_bus.enable, 0);
        chk("rst_s_addr", s_bus.addr, 0);
        chk("rst_m0_ready", m0_bus.ready, 0);
        chk("rst_m1_ready", m1_bus.ready, 0);
        chk("rst_m0_o_data", m0_bus.o_data, 0);

        // Both masters request together, three transactions each.
        m0_bus.enable = 1'b1;
        m1_bus.enable = 1'b1;
        for (int k = 0; k < 6; k++) begin
            serve(k % 2, 32'h1000 + k, 2);
            if (k < 4) begin
                if ((k % 2) != 0) m1_bus.enable = 1'b1;
                else              m0_bus.enable = 1'b1;
            end
        end

        // Lone m0 read, slave answers 3 cycles after s_enable.
        m0_bus.enable = 1'b1;
        serve(0, 32'hDEAD_BEEF, 3);
        step();
        chk("m0_o_data_hold", m0_bus.o_data, 32'hDEAD_BEEF);
        chk("m1_o_data_hold", m1_bus.o_data, 32'h1005);

        // Timeout: slave silent, completion exactly 8 cycles after s_enable.
        m0_bus.enable = 1'b1;
        step();
        chk("to_s_enable", s_bus.enable, 1);
        repeat (7) step();
        chk("to_not_yet", m0_bus.ready, 0);
        chk("to_s_enable_held", s_bus.enable, 1);
        step();
        chk("to_ready", m0_bus.ready, 1);
        chk("to_bus_err", m0_bus.bus_err, 1);
        chk("to_o_data", m0_bus.o_data, 0);
        chk("to_s_enable_fall", s_bus.enable, 0);
        m0_bus.enable = 1'b0;
        step();
        chk("to_err_clear", m0_bus.bus_err, 0);
        chk("to_grant_idle", grant, 2'b00);

        // Reset mid-BUSY with m0 owning; m0 was served last, so only a reset lets it win again.
        m0_bus.enable = 1'b1;
        step();
        chk("rb_grant", grant, 2'b01);
        step();
        m1_bus.enable = 1'b1;
        rst = 1'b1;
        step();
        chk("rb_grant_rst", grant, 2'b00);
        chk("rb_s_enable_rst", s_bus.enable, 0);
        chk("rb_m0_ready_rst", m0_bus.ready, 0);
        chk("rb_m1_ready_rst", m1_bus.ready, 0);
        rst = 1'b0;
        step();
        chk("rb_winner", grant, 2'b01);
        m0_bus.enable = 1'b0;
        m1_bus.enable = 1'b0;
        step();
        step();
        chk("rb_cleanup_idle", grant, 2'b00);

        // m1 write, abandoned 2 cycles into BUSY while the slave is late.
        m1_bus.wr_en  = 1'b1;
        m1_bus.addr   = 32'h2000_0000;
        m1_bus.be     = 4'b0001;
        m1_bus.i_data = 32'h0000_00A5;
        m1_bus.enable = 1'b1;
        step();
        chk("ab_grant", grant, 2'b10);
        chk("ab_s_wr_en", s_bus.wr_en, 1);
        chk("ab_s_addr", s_bus.addr, 32'h2000_0000);
        chk("ab_s_be", s_bus.be, 4'b0001);
        chk("ab_s_i_data", s_bus.i_data, 32'h0000_00A5);
        step();
        step();
        m1_bus.enable = 1'b0;
        step();
        chk("ab_s_enable_fall", s_bus.enable, 0);
        chk("ab_m1_ready", m1_bus.ready, 0);
        s_bus.ready = 1'b1;
        step();
        chk("ab_hold_grant", grant, 2'b10);
        chk("ab_m1_ready_late", m1_bus.ready, 0);
        s_bus.ready = 1'b0;
        step();
        chk("ab_grant_idle", grant, 2'b00);
        chk("ab_m1_ready_end", m1_bus.ready, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/lt100_bus_arbiter.md
LT100_BUS_ARBITER -- requirements
Module: lt100_bus_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, address width of all ports.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data width; byte enables are DATA_WIDTH/8 wide.
REQ-003 SHALL have parameter TIMEOUT, default 255, maximum cycles a grant waits for s_ready; 0 disables the timeout; legal range 0..65535.
REQ-004 SHALL have one clock and a synchronous, active-high reset.
REQ-005 clk  input  1  the single clock; all state updates on its rising edge.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 m0_enable, m1_enable  input  1  master request, held high until the master sees its ready.
REQ-008 m0_wr_en, m1_wr_en  input  1  write (1) or read (0).
REQ-009 m0_addr, m1_addr  input  ADDR_WIDTH  master address.
REQ-010 m0_i_data, m1_i_data  input  DATA_WIDTH  master write data.
REQ-011 m0_be, m1_be  input  DATA_WIDTH/8  master byte enables.
REQ-012 m0_ready, m1_ready  output  1  registered completion, held until that master drops enable.
REQ-013 m0_o_data, m1_o_data  output  DATA_WIDTH  registered read data.
REQ-014 m0_bus_err, m1_bus_err  output  1  registered error, valid while the matching ready is high.
REQ-015 s_enable, s_wr_en, s_addr, s_i_data, s_be  output  1/1/ADDR_WIDTH/DATA_WIDTH/DATA_WIDTH/8  registered request to the shared lt100_bus.
REQ-016 s_ready, s_o_data, s_bus_err  input  1/DATA_WIDTH/1  response from the shared lt100_bus.
REQ-017 grant  output  2  one-hot owning master ({m1,m0}); 2'b00 when idle.

Function
REQ-018 SHALL implement states IDLE, BUSY and DONE.
REQ-019 IDLE: when any mK_enable is high and s_ready is low, SHALL select a winner, copy that master's wr_en/addr/i_data/be to the s_* outputs, set s_enable=1, set grant, clear the timeout counter, and go to BUSY; s_enable rises 1 cycle after the sampled request.
REQ-020 Arbitration SHALL be round-robin: a lone requester wins; on simultaneous requests the master not served last wins; after reset m0 has priority.
REQ-021 BUSY: s_* outputs SHALL stay constant; the timeout counter (16 bits) SHALL increment each cycle.
REQ-022 BUSY with s_ready=1: SHALL register s_o_data and s_bus_err into the granted master's o_data/bus_err, set its ready=1, set s_enable=0, and go to DONE.
REQ-023 BUSY with TIMEOUT!=0 and counter==TIMEOUT-1 without s_ready: SHALL set the granted master's ready=1, bus_err=1, o_data=0, s_enable=0, and go to DONE; s_ready on that same cycle takes precedence over the timeout.
REQ-024 BUSY with the granted master's enable low (abort): SHALL set s_enable=0, assert no master ready, and go to DONE.
REQ-025 DONE: SHALL remain until the granted master's enable is low and s_ready is low, then clear that master's ready and bus_err, record it as last served, set grant=0, and go to IDLE.
REQ-026 The non-granted master SHALL see ready=0 and keep waiting; its request SHALL NOT be dropped.
REQ-027 A master SHALL NOT be granted twice in a row while the other master is requesting.
REQ-028 mK_o_data SHALL hold its last value until overwritten by a later completion for that master.

Reset
REQ-029 rst=1 SHALL force IDLE, grant=0, all mK_ready=0, mK_bus_err=0, mK_o_data=0, s_enable=0, s_wr_en=0, s_addr=0, s_i_data=0, s_be=0, counter=0, last served=m1, from any state, including mid-transaction.

Structure
REQ-030 State encodings and the arbiter grant-index constants SHALL live in shared package lt100_pkg.
REQ-031 The block SHALL be a single module with no sub-modules; it instantiates between the masters and lt100_bus.

Verification
REQ-032 m0 reads 0x0000_0010 alone, slave answers 3 cycles after s_enable with 0xDEAD_BEEF -> m0_ready=1, m0_o_data=0xDEAD_BEEF, m0_bus_err=0, m1_ready stays 0.
REQ-033 m0 and m1 request in the same cycle, held through 3 transactions each -> grant order m0,m1,m0,m1,m0,m1.
REQ-034 TIMEOUT=8, slave never asserts s_ready -> granted master's ready=1 with bus_err=1 and o_data=0 exactly 8 cycles after s_enable rises; s_enable=0 the same cycle.
REQ-035 m1 write to 0x2000_0000 with be=4'b0001, m1 drops enable 2 cycles into BUSY -> s_enable falls next cycle, m1_ready never asserts, arbiter returns to IDLE once s_ready is low.
REQ-036 rst asserted while in BUSY with m0 granted -> next cycle grant=0, s_enable=0, all ready=0; with m0 and m1 then requesting together, m0 wins.
